// File: rtl/mem_lsu.sv
// mem_lsu : load/store unit acting as initiator on a word-wide synchronous
// memory port with a one-cycle registered read.
//
// Accepts byte/half/word(/double when DW=64) load and store requests over a
// valid/ready handshake, one at a time. Loads have their lane extracted and
// are sign- or zero-extended. Sub-word stores are read-modify-write, since the
// memory only writes whole words.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_size,        store flag, access size (00 B, 01 H, 10 W, 11 D),
//   req_unsigned             zero-extend loads when set
//   req_addr, req_wdata      byte address, right-justified store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     extended load data (0 for stores), error flag
//   mem_address              word-aligned memory address
//   mem_write_data           word to write
//   mem_read, mem_write      memory strobes (never both high)
//   mem_read_data            memory data, valid the cycle after mem_read
//
// Optional feature: define MEM_LSU_MISALIGN_CHECK_EN to report misaligned or
// illegal-size requests through resp_err. Without it, resp_err is 0,
// misaligned addresses are force-aligned and size 11 with DW=32 acts as a word.
module mem_lsu #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [63:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [63:0]   mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data
);

  localparam int LB = $clog2(DW) - 3;

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_DATA, RMW_RD, RMW_MERGE, ST_WR, RESP
  } state_t;

  state_t state, state_nx;

  logic [1:0]    size_q;
  logic [LB-1:0] off_q;
  logic          uns_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] merge_q;
  logic [DW-1:0] rdata_q;
  logic [63:0]   maddr_q;

  // Byte offset bits that must be zero for an access of the given size.
  function automatic logic [2:0] low_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Mask covering the low (8 << sz) bits of a DW-wide word.
  function automatic logic [DW-1:0] lane_mask(input logic [1:0] sz);
    int nb;
    nb = 8 << sz;
    if (nb >= DW) return '1;
    return ~({DW{1'b1}} << nb);
  endfunction

  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w,
                                             input logic [LB-1:0] off,
                                             input logic [1:0]    sz,
                                             input logic          uns);
    logic [DW-1:0] s;
    logic [DW-1:0] m;
    logic          sgn;
    s   = w >> {off, 3'b000};
    m   = lane_mask(sz);
    // Top bit of the lane: the one bit set in m but not in m >> 1.
    sgn = |(s & m & ~(m >> 1));
    if (uns || !sgn) return s & m;
    return (s & m) | ~m;
  endfunction

  function automatic logic [DW-1:0] merge_lane(input logic [DW-1:0] rd,
                                               input logic [DW-1:0] wd,
                                               input logic [LB-1:0] off,
                                               input logic [1:0]    sz);
    logic [DW-1:0] m;
    m = lane_mask(sz);
    return (rd & ~(m << {off, 3'b000})) | ((wd & m) << {off, 3'b000});
  endfunction

  // Request decode: size 11 is only meaningful on a 64-bit port.
  logic [1:0]    esize_in;
  logic [2:0]    lm_in;
  logic [LB-1:0] off_in;
  logic          full_in;
  logic          err_in;

  always_comb begin
    esize_in = (req_size == 2'b11 && DW == 32) ? 2'b10 : req_size;
    lm_in    = low_mask(esize_in);
    off_in   = req_addr[LB-1:0] & ~lm_in[LB-1:0];
    full_in  = ((8 << esize_in) == DW);
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    err_in   = ((req_addr[2:0] & low_mask(req_size)) != 3'b000) ||
               (req_size == 2'b11 && DW == 32);
`else
    err_in   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (req_valid) begin
          if (err_in)       state_nx = RESP;
          else if (!req_we) state_nx = LD_ISSUE;
          else if (full_in) state_nx = ST_WR;
          else              state_nx = RMW_RD;
        end
      LD_ISSUE:  state_nx = LD_DATA;
      LD_DATA:   state_nx = RESP;
      RMW_RD:    state_nx = RMW_MERGE;
      RMW_MERGE: state_nx = ST_WR;
      ST_WR:     state_nx = RESP;
      RESP:      if (resp_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

`ifdef MEM_LSU_MISALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)                                 err_q <= 1'b0;
    else if (state == IDLE && req_valid)     err_q <= err_in;
    else if (state == RESP && resp_ready)    err_q <= 1'b0;
  end
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      maddr_q <= '0;
    end else begin
      case (state)
        IDLE:
          if (req_valid) begin
            size_q  <= esize_in;
            off_q   <= off_in;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            maddr_q <= {req_addr[63:LB], {LB{1'b0}}};
            if (req_we && full_in) merge_q <= req_wdata;
          end
        LD_DATA:   rdata_q <= load_ext(mem_read_data, off_q, size_q, uns_q);
        RMW_MERGE: merge_q <= merge_lane(mem_read_data, wdata_q, off_q, size_q);
        RESP:      if (resp_ready) rdata_q <= '0;
        default: ;
      endcase
    end
  end

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_rdata     = rdata_q;
  assign mem_address    = maddr_q;
  assign mem_write_data = merge_q;
  // Strobes are gated by rst so a reset cycle never touches memory.
  assign mem_read       = !rst && (state == LD_ISSUE || state == RMW_RD);
  assign mem_write      = !rst && (state == ST_WR);

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit that acts as the initiator on the word-wide synchronous memory port (`address`, `write_data`, `mem_read`, `mem_write`, `read_data`, one-cycle registered read). It accepts byte, half and word load/store requests from the core's execute/memory stage over a valid/ready handshake. It performs lane extraction and sign or zero extension on loads. Sub-word stores are done as read-modify-write, because the memory only writes whole words.

## Interface
- `DW`, 32: memory data width. Legal values are 32 or 64. Lane bits `LB = $clog2(DW)-3`.
- `clk` in 1: clock. All logic is clocked on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block is able to accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = double (legal only when DW=64).
- `req_unsigned` in 1: loads are zero-extended when set, sign-extended when clear.
- `req_addr` in 64: byte address.
- `req_wdata` in DW: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out DW: extended load data. 0 for stores.
- `resp_err` out 1: misaligned or illegal-size access.
- `mem_address` out 64: word-aligned address. Low `LB` bits are always 0.
- `mem_write_data` out DW: word to write.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe.
- `mem_read_data` in DW: memory read data. Valid in the cycle after `mem_read`.

## Operation
- The FSM has seven states: IDLE, LD_ISSUE, LD_DATA, RMW_RD, RMW_MERGE, ST_WR, RESP.
- **IDLE**
  - `req_ready`=1.
  - When `req_valid` is 1, the block captures addr, size, we, unsigned and wdata into registers.
  - Next state:
    - error → RESP with `resp_err`=1, and no memory access is made.
    - load → LD_ISSUE.
    - store with size equal to the full DW → ST_WR, with the merge register set to wdata.
    - sub-word store → RMW_RD.
- **LD_ISSUE**: `mem_read`=1, then → LD_DATA.
- **LD_DATA**
  - Select the lane at byte offset `addr[LB-1:0]` from `mem_read_data`. Lanes are little-endian, so byte k is `[8k+7:8k]`.
  - Extend the lane to DW according to `req_unsigned` and register it into `resp_rdata`.
  - → RESP.
- **RMW_RD**: `mem_read`=1, then → RMW_MERGE.
- **RMW_MERGE**
  - Replace the addressed lane of `mem_read_data` with the low bytes of the captured wdata.
  - All other bytes are left unchanged.
  - Register the merged word, then → ST_WR.
- **ST_WR**: `mem_write`=1 with `mem_write_data` set to the merge register, then → RESP.
- **RESP**
  - `resp_valid`=1. `resp_rdata` and `resp_err` are held stable.
  - When `resp_ready` is 1: → IDLE, `resp_valid` drops, and `resp_rdata`/`resp_err` clear to 0.
- `mem_address` = {captured addr[63:LB], LB'b0}. It is registered when the request is accepted.
- `mem_read` and `mem_write` are decoded from state and gated by `!rst`, so no access is issued in a reset cycle.
- `mem_read` and `mem_write` are never both 1.
- Only one request is in flight at a time. `req_ready`=0 in every state except IDLE, so a new request cannot be accepted in the same cycle that RESP completes.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready`=1
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0
  - `mem_address`=0, `mem_write_data`=0
  - `mem_read`=0, `mem_write`=0
  - all capture registers = 0
- Latency, measured from the acceptance edge (cycle 0) to the first cycle in which `resp_valid`=1:
  - load: 3 cycles
  - full-width store: 2 cycles
  - sub-word store: 4 cycles
  - error: 1 cycle
- `resp_valid` stays high until `resp_ready`. Backpressure can last any number of cycles without changing the response fields.
- Reset in the middle of an operation:
  - The request is abandoned, with no response and no further memory access.
  - The state is in IDLE on the cycle after reset deasserts.
  - If the reset cycle is an ST_WR cycle, the write is suppressed.
- Alignment rule: a request is misaligned if `addr % (1<<size) != 0`. Examples: a half access at addr[0]=1; a word access with addr[1:0]≠0 when DW=32.

## Configuration
- `MEM_LSU_MISALIGN_CHECK_EN` defined:
  - Misaligned requests and size=11 with DW=32 produce `resp_err`=1, with no memory access and 1-cycle latency.
- Macro undefined:
  - `resp_err` is tied to 0.
  - Misaligned requests are force-aligned: addr low bits below the size are treated as 0.
  - size=11 with DW=32 is treated as a word access.

## Test plan
- **Word store/load (DW=32)**
  - Stimulus: store word 0xDEADBEEF @0x10, then load word @0x10.
  - Response: `mem_write` is seen in the cycle after acceptance, with `mem_address`=0x10. Load returns `resp_rdata`=0xDEADBEEF at 3-cycle latency.
- **Signed/unsigned byte loads**
  - Stimulus: memory @0x10 holds 0x80FF7F01.
  - Response:
    - signed byte @0x13 → 0xFFFFFF80
    - unsigned byte @0x12 → 0x000000FF
    - signed half @0x10 → 0x00007F01
- **Byte store RMW**
  - Stimulus: memory @0x20 holds 0x11223344. Store byte 0xAB @0x21.
  - Response: exactly one `mem_read` then one `mem_write` of 0x1122AB44. `resp_valid` at cycle 4.
- **Misalignment with `MEM_LSU_MISALIGN_CHECK_EN`**
  - Stimulus: load half @0x11.
  - Response: `resp_err`=1 at cycle 1, and `mem_read`/`mem_write` stay 0 throughout.
- **Response backpressure**
  - Stimulus: hold `resp_ready`=0 for 5 cycles.
  - Response: `resp_valid` and `resp_rdata` stay stable and `req_ready` stays 0. IDLE is reached the cycle after `resp_ready`=1.
- **Reset mid-RMW**
  - Stimulus: assert `rst` for 1 cycle while in ST_WR.
  - Response: no write occurs (memory word unchanged), all outputs return to reset values, and `req_ready`=1 on the next cycle.
